counter_up_dwn_multi: RTL and testbench
=======================================

// Module: counter_up_dwn_multi
// PURPOSE
//  Parametrised up/down counter with load, per-cycle enable, programmable step and modulus.
//  Three modes: wrap (modulo max_val+1), saturate, and one-shot (run to terminal, then stop).
//  Drives terminal-count pulses and sticky overflow/underflow flags for timers, address
//  generators and event counters across the design.
// PARAMETERS
//  WIDTH   8  counter, data and max_val width
//  STEP_W  4  step input width; STEP_W <= WIDTH
// PORTS
//  clk        in   1        rising-edge clock; the only clock
//  reset      in   1        asynchronous, active-low reset (0 = reset)
//  clr        in   1        synchronous clear: out=0, flags=0, FSM=IDLE
//  load       in   1        out <= min(data, max_val)
//  data       in   WIDTH    load value
//  en         in   1        count enable
//  up_dwn     in   1        1 = count up, 0 = count down
//  step       in   STEP_W   increment/decrement amount
//  max_val    in   WIDTH    upper bound (modulus = max_val+1)
//  mode       in   2        00 wrap, 01 saturate, 10 one-shot, 11 hold
//  clr_flags  in   1        synchronous clear of ovf/unf only
//  out        out  WIDTH    count value
//  tc         out  1        registered 1-cycle terminal-count pulse
//  ovf        out  1        sticky: up-count crossed or clamped at max_val
//  unf        out  1        sticky: down-count crossed or clamped at 0
//  done       out  1        one-shot finished; held until load/clr/reset
// BEHAVIOUR
//  - reset=0: out=0, tc=0, ovf=0, unf=0, done=0, FSM=IDLE, immediately and without clk.
//  - Priority per edge: clr > load > count (en=1) > hold. All updates have 1-cycle latency.
//  - Effective step s = min(zero-extended step, max_val). Arithmetic uses WIDTH+1 bits.
//  - out > max_val when a count is due (max_val lowered at runtime): out <= max_val;
//    set ovf; no tc.
//  - step=0 with en=1: out unchanged; no flags; no tc.
//  - Wrap, up: if out+s > max_val then out <= out+s-(max_val+1), set ovf, pulse tc;
//    else out <= out+s.
//  - Wrap, down: if s > out then out <= out-s+max_val+1, set unf, pulse tc;
//    else out <= out-s.
//  - Saturate: up clamps at max_val, down clamps at 0.
//    Clamping sets ovf/unf; landing exactly on the bound does not. tc never pulses.
//  - One-shot FSM IDLE -> RUN -> DONE:
//    - load moves any state to RUN and clears done.
//    - In RUN with en=1, counts as saturate. On reaching max_val (up) or 0 (down),
//      go to DONE, set done=1, pulse tc.
//    - IDLE and DONE ignore en; out holds.
//  - mode 11: out holds; load and clr still act.
//  - mode may change on any cycle. FSM state persists across a mode change.
//    The FSM advances only while mode=10.
//  - clr_flags clears ovf/unf. If a flag event occurs in the same cycle, the flag is set
//    (set wins).
//  - load and en on the same cycle: load only, no flag, no tc.
//  - tc is high exactly one cycle after the qualifying edge, then low.
//  - reset asserted mid-count: all state returns to reset values asynchronously.
//    Counting resumes on the first edge after reset deasserts.
// STRUCTURE
//  - Package counter_pkg:
//    - mode_e {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_HOLD}
//    - os_state_e {OS_IDLE, OS_RUN, OS_DONE}
//  - Sub-module counter_step_calc (combinational): takes out, s, max_val, up_dwn, mode.
//    Returns next value plus cross/clamp/terminal indicators.
//  - Top holds the registers, FSM and flag logic.
// TESTING  (WIDTH=8, STEP_W=4)
//  1. reset=0 mid-count with out=0x37 -> out=0, flags=0 at once without clk;
//     en=1 after release -> out=1 on the 1st edge.
//  2. Wrap: max_val=9, step=3, up, load 8, en 1 cycle -> out=1, ovf=1, tc high 1 cycle.
//     Down from 1, step=3 -> out=8, unf=1.
//  3. Saturate: max_val=9, step=4, up from 7 -> 9, ovf=1, tc=0.
//     Down from 2 -> 0, unf=1. clr_flags -> ovf=unf=0.
//  4. One-shot: max_val=5, step=2, up, load 0, en held -> out 2,4,5, done=1, tc pulse.
//     Further en -> out stays 5. load 1 -> RUN, done=0.
//  5. Simultaneous events: load=1 with en=1, data=200, max_val=100 -> out=100, no flags.
//     clr with load -> out=0.
//  6. Runtime bound change: out=50, then max_val=20 and en -> out=20, ovf=1.
//     step=15 with max_val=10 -> effective step 10.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the multi-mode up/down counter: operating mode and one-shot state.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package counter_pkg;

    // Encodings match the 2-bit mode input pins directly.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        OS_IDLE = 2'b00,
        OS_RUN  = 2'b01,
        OS_DONE = 2'b10
    } os_state_e;

    // Modes that count on every enabled cycle without consulting the one-shot FSM.
    function automatic logic is_free_running(input mode_e m);
        return (m == MODE_WRAP) || (m == MODE_SAT);
    endfunction

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-value calculator: given the current count, effective step, bound,
// direction and mode, returns the next count plus overflow/underflow/wrap/terminal hints.
// Latency: 0 cycles (pure combinational). Backpressure: none.
//
// Ports:
//   cur      current count          s        effective step (already <= max_val)
//   max_val  upper bound             up_dwn   1 = up, 0 = down
//   mode     wrap selects modulo arithmetic; anything else clamps at the bounds
//   nxt      next count              ovf_evt  up-count crossed/clamped, or cur above bound
//   unf_evt  down-count crossed/clamped at zero
//   wrap_evt modulo wrap happened (wrap mode only)
//   terminal next count lands on the bound in the counting direction
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] max_val,
    input  logic             up_dwn,
    input  mode_e            mode,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf_evt,
    output logic             unf_evt,
    output logic             wrap_evt,
    output logic             terminal
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    // One extra bit so out+s and out+max_val+1 never lose their carry.
    logic [WIDTH:0] cur_ext;
    logic [WIDTH:0] s_ext;
    logic [WIDTH:0] max_ext;
    logic [WIDTH:0] sum;
    logic           above;
    logic           over_up;
    logic           under_dn;

    always_comb begin
        cur_ext  = {1'b0, cur};
        s_ext    = {1'b0, s};
        max_ext  = {1'b0, max_val};
        sum      = cur_ext + s_ext;
        above    = cur > max_val;
        over_up  = sum > max_ext;
        under_dn = s > cur;

        nxt      = cur;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        wrap_evt = 1'b0;
        terminal = 1'b0;

        if (above) begin
            // Bound was lowered underneath us: snap back into range. This is a
            // correction, not a count, so it never reports terminal or wrap.
            nxt     = max_val;
            ovf_evt = 1'b1;
        end else if (s != '0) begin
            if (up_dwn) begin
                if (over_up) begin
                    ovf_evt = 1'b1;
                    if (mode == MODE_WRAP) begin
                        nxt      = WIDTH'(sum - max_ext - ONE);
                        wrap_evt = 1'b1;
                    end else begin
                        nxt = max_val;
                    end
                end else begin
                    nxt = sum[WIDTH-1:0];
                end
                terminal = (nxt == max_val);
            end else begin
                if (under_dn) begin
                    unf_evt = 1'b1;
                    if (mode == MODE_WRAP) begin
                        // s <= max_val, so cur+max_val+1-s stays within 0..max_val.
                        nxt      = WIDTH'(cur_ext + max_ext + ONE - s_ext);
                        wrap_evt = 1'b1;
                    end else begin
                        nxt = '0;
                    end
                end else begin
                    nxt = cur - s;
                end
                terminal = (nxt == '0);
            end
        end
    end

endmodule

// File: rtl/counter_up_dwn_multi.sv
// Multi-mode up/down counter (wrap / saturate / one-shot / hold) with load, clear,
// programmable step and runtime bound, terminal-count pulse and sticky ovf/unf flags.
// Latency: 1 cycle from qualifying edge to out/tc/flags. Backpressure: none (en gates counting).
//
// Ports:
//   clk, reset (async active-low)   clr (sync clear all)   load/data (load min(data,max_val))
//   en, up_dwn, step                max_val (bound)        mode (00 wrap 01 sat 10 one-shot 11 hold)
//   clr_flags (clear ovf/unf)       out, tc, ovf, unf, done
module counter_up_dwn_multi
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    input  logic              en,
    input  logic              up_dwn,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    input  logic [1:0]        mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              done
);

    mode_e            mode_i;
    logic [WIDTH-1:0] step_ext;
    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] load_val;
    logic             count_due;

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             done_q, done_d;
    os_state_e        state_q, state_d;

    logic [WIDTH-1:0] calc_nxt;
    logic             calc_ovf;
    logic             calc_unf;
    logic             calc_wrap;
    logic             calc_term;

    always_comb begin
        mode_i   = mode_e'(mode);
        step_ext = WIDTH'(step);
        // A step larger than the bound is trimmed so one count never wraps twice.
        s_eff    = (step_ext > max_val) ? max_val : step_ext;
        load_val = (data > max_val) ? max_val : data;
        // One-shot only counts while running; IDLE/DONE ignore en.
        count_due = en && (is_free_running(mode_i) ||
                           ((mode_i == MODE_ONESHOT) && (state_q == OS_RUN)));
    end

    counter_step_calc #(
        .WIDTH (WIDTH)
    ) u_step_calc (
        .cur      (out_q),
        .s        (s_eff),
        .max_val  (max_val),
        .up_dwn   (up_dwn),
        .mode     (mode_i),
        .nxt      (calc_nxt),
        .ovf_evt  (calc_ovf),
        .unf_evt  (calc_unf),
        .wrap_evt (calc_wrap),
        .terminal (calc_term)
    );

    // Next-state and output logic; the one-shot FSM lives here too.
    always_comb begin
        out_d   = out_q;
        state_d = state_q;
        done_d  = done_q;
        tc_d    = 1'b0;
        // Clear first, then OR in this cycle's events so a same-cycle event wins.
        ovf_d   = ovf_q & ~clr_flags;
        unf_d   = unf_q & ~clr_flags;

        if (clr) begin
            out_d   = '0;
            state_d = OS_IDLE;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (load) begin
            // Load re-arms the one-shot from any state and raises no flags.
            out_d   = load_val;
            state_d = OS_RUN;
            done_d  = 1'b0;
        end else if (count_due) begin
            out_d = calc_nxt;
            ovf_d = ovf_d | calc_ovf;
            unf_d = unf_d | calc_unf;
            case (mode_i)
                MODE_WRAP: tc_d = calc_wrap;
                MODE_ONESHOT: begin
                    if (calc_term) begin
                        state_d = OS_DONE;
                        done_d  = 1'b1;
                        tc_d    = 1'b1;
                    end
                end
                default: tc_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= OS_IDLE;
        end else begin
            out_q   <= out_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_up_dwn_multi.sv
// Self-checking bench: directed scenarios plus randomized stimulus against an
// arithmetic reference model of the counter.
// Latency: model expects every update one edge after inputs are applied.
module tb_counter_up_dwn_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       load;
    logic [7:0] data;
    logic       en;
    logic       up_dwn;
    logic [3:0] step;
    logic [7:0] max_val;
    logic [1:0] mode;
    logic       clr_flags;
    logic [7:0] out;
    logic       tc;
    logic       ovf;
    logic       unf;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state: plain integers; running/finished describe the one-shot.
    int m_out;
    bit m_tc, m_ovf, m_unf, m_done, m_running;

    always #5 clk = ~clk;

    counter_up_dwn_multi #(
        .WIDTH  (8),
        .STEP_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .load      (load),
        .data      (data),
        .en        (en),
        .up_dwn    (up_dwn),
        .step      (step),
        .max_val   (max_val),
        .mode      (mode),
        .clr_flags (clr_flags),
        .out       (out),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_done = 0; m_running = 0;
    endtask

    // What one rising edge does, from the behavioural rules.
    task automatic model_edge();
        int mx, s, nv;
        mx = int'(max_val);
        s  = (int'(step) > mx) ? mx : int'(step);
        m_tc = 0;
        if (clr) begin
            model_reset();
            return;
        end
        if (clr_flags) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (load) begin
            m_out     = (int'(data) < mx) ? int'(data) : mx;
            m_running = 1;
            m_done    = 0;
        end else if (en && (mode == 2'd0 || mode == 2'd1 || (mode == 2'd2 && m_running))) begin
            if (m_out > mx) begin
                m_out = mx;
                m_ovf = 1;
            end else if (s != 0) begin
                nv = up_dwn ? m_out + s : m_out - s;
                if (mode == 2'd0) begin
                    if (nv > mx) begin m_ovf = 1; m_tc = 1; end
                    if (nv < 0)  begin m_unf = 1; m_tc = 1; end
                    m_out = (nv + mx + 1) % (mx + 1);
                end else begin
                    if (nv > mx) begin m_ovf = 1; nv = mx; end
                    if (nv < 0)  begin m_unf = 1; nv = 0;  end
                    m_out = nv;
                    if (mode == 2'd2 && ((up_dwn && nv == mx) || (!up_dwn && nv == 0))) begin
                        m_running = 0;
                        m_done    = 1;
                        m_tc      = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out"},  out,  m_out);
        chk({tag, ".tc"},   tc,   m_tc);
        chk({tag, ".ovf"},  ovf,  m_ovf);
        chk({tag, ".unf"},  unf,  m_unf);
        chk({tag, ".done"}, done, m_done);
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        clr = 0; load = 0; en = 0; clr_flags = 0;
    endtask

    initial begin
        reset = 0; clr = 0; load = 0; data = 0; en = 0; up_dwn = 1;
        step = 1; max_val = 8'd255; mode = 2'd0; clr_flags = 0;
        model_reset();
        #12;
        compare_all("rst");
        reset = 1;
        #1;

        // 1: async reset mid-count, then resume
        load = 1; data = 8'h37; tick("t1_load");
        chk("t1_out37", out, 8'h37);
        load = 0; en = 1; tick("t1_cnt");
        #2 reset = 0;
        #1;
        model_reset();
        chk("t1_async_out", out, 0);
        chk("t1_async_ovf", ovf, 0);
        compare_all("t1_async");
        #1 reset = 1;
        en = 1; step = 1; up_dwn = 1;
        tick("t1_resume");
        chk("t1_first", out, 1);

        // 2: wrap
        idle_inputs(); mode = 2'd0; max_val = 9; step = 3; up_dwn = 1;
        load = 1; data = 8; tick("t2_load");
        load = 0; en = 1; tick("t2_up");
        chk("t2_out", out, 1); chk("t2_ovf", ovf, 1); chk("t2_tc", tc, 1);
        en = 0; tick("t2_idle");
        chk("t2_tc_low", tc, 0);
        en = 1; up_dwn = 0; tick("t2_dn");
        chk("t2_dn_out", out, 8); chk("t2_unf", unf, 1);

        // 3: saturate
        idle_inputs(); clr = 1; tick("t3_clr");
        clr = 0; mode = 2'd1; max_val = 9; step = 4; up_dwn = 1;
        load = 1; data = 7; tick("t3_load");
        load = 0; en = 1; tick("t3_up");
        chk("t3_out", out, 9); chk("t3_ovf", ovf, 1); chk("t3_tc", tc, 0);
        en = 0; load = 1; data = 2; tick("t3_load2");
        load = 0; en = 1; up_dwn = 0; tick("t3_dn");
        chk("t3_dn_out", out, 0); chk("t3_unf", unf, 1);
        en = 0; clr_flags = 1; tick("t3_cf");
        chk("t3_cf_ovf", ovf, 0); chk("t3_cf_unf", unf, 0);

        // 4: one-shot
        idle_inputs(); clr = 1; tick("t4_clr");
        clr = 0; mode = 2'd2; max_val = 5; step = 2; up_dwn = 1;
        load = 1; data = 0; tick("t4_load");
        load = 0; en = 1;
        tick("t4_c1"); chk("t4_out2", out, 2);
        tick("t4_c2"); chk("t4_out4", out, 4);
        tick("t4_c3"); chk("t4_out5", out, 5); chk("t4_done", done, 1); chk("t4_tc", tc, 1);
        tick("t4_c4"); chk("t4_hold", out, 5); chk("t4_tc_low", tc, 0);
        en = 0; load = 1; data = 1; tick("t4_reload");
        chk("t4_rearm_done", done, 0); chk("t4_rearm_out", out, 1);
        load = 0; en = 1; tick("t4_run"); chk("t4_run_out", out, 3);

        // 5: simultaneous events
        idle_inputs(); clr = 1; tick("t5_clr");
        clr = 0; mode = 2'd0; max_val = 100; load = 1; en = 1; data = 200; up_dwn = 1;
        tick("t5_load_en");
        chk("t5_out", out, 100); chk("t5_ovf", ovf, 0); chk("t5_tc", tc, 0);
        clr = 1; tick("t5_clr_load");
        chk("t5_clr_out", out, 0);

        // 6: runtime bound change and step trimming
        idle_inputs(); mode = 2'd0; max_val = 255; load = 1; data = 50; tick("t6_load");
        load = 0; en = 1; max_val = 20; tick("t6_lower");
        chk("t6_out", out, 20); chk("t6_ovf", ovf, 1); chk("t6_tc", tc, 0);
        en = 0; load = 1; data = 0; max_val = 10; step = 15; tick("t6_load0");
        load = 0; en = 1; tick("t6_trim");
        chk("t6_trim_out", out, 10);
        tick("t6_wrap"); chk("t6_wrap_out", out, 9); chk("t6_wrap_tc", tc, 1);

        // Randomized run
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                max_val = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            en        = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 9) == 0);
            clr       = ($urandom_range(0, 39) == 0);
            clr_flags = ($urandom_range(0, 14) == 0);
            up_dwn    = ($urandom_range(0, 5) != 0) ? up_dwn : ~up_dwn;
            step      = 4'($urandom);
            data      = 8'($urandom);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
